// File: rtl/ex_exc_issue.sv
// EX-stage exception generator: prioritises per-way exception flags into CP0 codes,
// tracks branch delay slots across bundles and squashes output for a window after a flush.
module ex_exc_issue_way (
  input  logic       i_valid,
  input  logic [1:0] i_pc_lo,
  input  logic       i_ri,
  input  logic       i_syscall,
  input  logic       i_eret,
  input  logic       i_ov,
  input  logic       i_load,
  input  logic       i_store,
  input  logic [1:0] i_maddr,
  input  logic [1:0] i_msize,
  output logic [4:0] o_code
);
  logic w_mis;

  // byte accesses (and the unused size 11) are never misaligned
  assign w_mis = ((i_msize == 2'b01) & i_maddr[0]) |
                 ((i_msize == 2'b10) & (i_maddr != 2'b00));

  always_comb begin
    o_code = 5'h10;
    if (i_valid) begin
      if (i_pc_lo != 2'b00)     o_code = 5'h04;
      else if (i_ri)            o_code = 5'h0a;
      else if (i_syscall)       o_code = 5'h08;
      else if (i_eret)          o_code = 5'h11;
      else if (i_ov)            o_code = 5'h0c;
      else if (i_load & w_mis)  o_code = 5'h04;
      else if (i_store & w_mis) o_code = 5'h05;
    end
  end
endmodule

module ex_exc_issue #(
  parameter int FLUSH_SQUASH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  in_valid,
  input  logic [63:0] in_pc,
  input  logic [1:0]  in_branch,
  input  logic [1:0]  in_ri,
  input  logic [1:0]  in_syscall,
  input  logic [1:0]  in_eret,
  input  logic [1:0]  in_ov,
  input  logic [1:0]  in_load,
  input  logic [1:0]  in_store,
  input  logic [3:0]  in_maddr,
  input  logic [3:0]  in_msize,
  input  logic        stall,
  input  logic        exc_flush_all,
  output logic [63:0] ex_cp0_exc_pc_o,
  output logic [1:0]  ex_cp0_in_delay_o,
  output logic [9:0]  ex_cp0_exc_code_o,
  output logic [1:0]  way_kill_o,
  output logic        squash_o
);
  localparam logic [4:0] C_NONE    = 5'h10;
  localparam logic [4:0] C_ERET    = 5'h11;
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;
  localparam logic [2:0] CNT_LD    = 3'(FLUSH_SQUASH - 1);

  logic [1:0][4:0] w_code;
  logic [9:0]      w_code_f;
  logic [1:0]      w_kill;
  logic [1:0]      w_dly;
  logic [63:0]     w_pc;
  logic            w_sup;
  logic            w_acc;
  logic [0:0]      r_state;
  logic [2:0]      r_cnt;
  logic            r_dly_pend;

  for (genvar g = 0; g < 2; g++) begin : g_way
    ex_exc_issue_way u_way (
      .i_valid   (in_valid[g]),
      .i_pc_lo   (in_pc[32*g +: 2]),
      .i_ri      (in_ri[g]),
      .i_syscall (in_syscall[g]),
      .i_eret    (in_eret[g]),
      .i_ov      (in_ov[g]),
      .i_load    (in_load[g]),
      .i_store   (in_store[g]),
      .i_maddr   (in_maddr[2*g +: 2]),
      .i_msize   (in_msize[2*g +: 2]),
      .o_code    (w_code[g])
    );
  end

  // any non-NONE way0 code (ERET included) blocks the younger way
  assign w_sup    = (w_code[0] != C_NONE);
  assign w_code_f = {w_sup ? C_NONE : w_code[1], w_code[0]};
  assign w_kill[0] = (w_code[0] != C_NONE) & (w_code[0] != C_ERET);
  assign w_kill[1] = w_sup | ((w_code[1] != C_NONE) & (w_code[1] != C_ERET));
  assign w_dly    = {in_valid[0] & in_branch[0], r_dly_pend};
  assign w_pc     = {in_valid[1] ? in_pc[63:32] : 32'h0, in_valid[0] ? in_pc[31:0] : 32'h0};
  assign w_acc    = (r_state == ST_RUN) & !stall & !exc_flush_all;
  assign squash_o = (r_state == ST_SQUASH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state           <= ST_RUN;
      r_cnt             <= 3'd0;
      r_dly_pend        <= 1'b0;
      ex_cp0_exc_code_o <= {C_NONE, C_NONE};
      ex_cp0_exc_pc_o   <= 64'h0;
      ex_cp0_in_delay_o <= 2'b00;
      way_kill_o        <= 2'b00;
    end else begin
      if (exc_flush_all) begin
        r_state    <= ST_SQUASH;
        r_cnt      <= CNT_LD;
        r_dly_pend <= 1'b0;
      end else if (r_state == ST_SQUASH) begin
        if (r_cnt == 3'd0) r_state <= ST_RUN;
        else               r_cnt   <= r_cnt - 3'd1;
      end else if (w_acc && in_valid != 2'b00) begin
        r_dly_pend <= in_valid[1] ? in_branch[1] : in_branch[0];
      end

      if (w_acc) begin
        ex_cp0_exc_code_o <= w_code_f;
        ex_cp0_exc_pc_o   <= w_pc;
        ex_cp0_in_delay_o <= w_dly;
        way_kill_o        <= w_kill;
      end else begin
        ex_cp0_exc_code_o <= {C_NONE, C_NONE};
        ex_cp0_in_delay_o <= 2'b00;
        way_kill_o        <= 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_ex_exc_issue.sv
// Directed bench for ex_exc_issue: vector table for priority/suppression/delay, hand sequences for flush and reset.
module tb_ex_exc_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid, in_branch, in_ri, in_syscall, in_eret, in_ov, in_load, in_store;
  logic [63:0] in_pc;
  logic [3:0]  in_maddr, in_msize;
  logic        stall, exc_flush_all;
  logic [63:0] pc_o;
  logic [1:0]  dly_o, kill_o;
  logic [9:0]  code_o;
  logic        squash_o;
  int          n_tests = 0;
  int          n_fail  = 0;

  ex_exc_issue #(.FLUSH_SQUASH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_branch(in_branch),
    .in_ri(in_ri), .in_syscall(in_syscall), .in_eret(in_eret), .in_ov(in_ov),
    .in_load(in_load), .in_store(in_store), .in_maddr(in_maddr), .in_msize(in_msize),
    .stall(stall), .exc_flush_all(exc_flush_all), .ex_cp0_exc_pc_o(pc_o),
    .ex_cp0_in_delay_o(dly_o), .ex_cp0_exc_code_o(code_o), .way_kill_o(kill_o),
    .squash_o(squash_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v, br, ri, sy, er, ov, ld, st;
    logic [63:0] pc;
    logic [3:0]  ma, ms;
    logic        stall;
    logic [9:0]  e_code;
    logic [63:0] e_pc;
    logic [1:0]  e_dly, e_kill;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = 0; in_pc = 0; in_branch = 0; in_ri = 0; in_syscall = 0; in_eret = 0;
    in_ov = 0; in_load = 0; in_store = 0; in_maddr = 0; in_msize = 0; stall = 0;
    exc_flush_all = 0;
  endtask

  task automatic apply(input vec_t t);
    in_valid = t.v; in_pc = t.pc; in_branch = t.br; in_ri = t.ri; in_syscall = t.sy;
    in_eret = t.er; in_ov = t.ov; in_load = t.ld; in_store = t.st; in_maddr = t.ma;
    in_msize = t.ms; stall = t.stall;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [63:0] pc, input logic [1:0] br,
      input logic [1:0] ri, input logic [1:0] sy, input logic [1:0] er, input logic [1:0] ov,
      input logic [1:0] ld, input logic [1:0] st, input logic [3:0] ma, input logic [3:0] ms,
      input logic stall, input logic [9:0] ec, input logic [63:0] ep, input logic [1:0] ed,
      input logic [1:0] ek);
    vec_t t;
    t.v = v; t.pc = pc; t.br = br; t.ri = ri; t.sy = sy; t.er = er; t.ov = ov; t.ld = ld;
    t.st = st; t.ma = ma; t.ms = ms; t.stall = stall; t.e_code = ec; t.e_pc = ep;
    t.e_dly = ed; t.e_kill = ek;
    return t;
  endfunction

  initial begin
    //           v   pc                      br  ri  sy  er  ov  ld  st  ma  ms  stl code    exp_pc                  dly kill
    tv[0]  = mk(3, 64'hbfc00004_bfc00000, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 10'h20a, 64'hbfc00004_bfc00000, 0, 3);
    tv[1]  = mk(3, 64'hbfc00004_bfc00000, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 10'h110, 64'hbfc00004_bfc00000, 0, 2);
    tv[2]  = mk(1, 64'h00000104_00000100, 0, 0, 0, 0, 0, 1, 0, 4'h2, 4'h2, 0, 10'h204, 64'h00000000_00000100, 0, 3);
    tv[3]  = mk(3, 64'h00000204_00000200, 0, 0, 0, 0, 0, 0, 2, 4'h4, 4'h4, 0, 10'h0b0, 64'h00000204_00000200, 0, 2);
    tv[4]  = mk(3, 64'h00000204_00000200, 0, 0, 0, 0, 0, 0, 2, 4'hc, 4'h0, 0, 10'h210, 64'h00000204_00000200, 0, 0);
    tv[5]  = mk(3, 64'h00001004_00001000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h210, 64'h00001004_00001000, 0, 0);
    tv[6]  = mk(1, 64'h0000100c_00001008, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10'h208, 64'h00000000_00001008, 1, 3);
    tv[7]  = mk(3, 64'h00002004_00002000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h210, 64'h00002004_00002000, 2, 0);
    tv[8]  = mk(1, 64'h00000000_00000202, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h204, 64'h00000000_00000202, 0, 3);
    tv[9]  = mk(3, 64'h00000301_00000300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h090, 64'h00000301_00000300, 0, 2);
    tv[10] = mk(3, 64'h00000404_00000400, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 10'h211, 64'h00000404_00000400, 0, 2);
    tv[11] = mk(3, 64'h00000504_00000500, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 10'h210, 64'h00000404_00000400, 0, 0);
    tv[12] = mk(3, 64'h00000504_00000500, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 10'h211, 64'h00000504_00000500, 0, 2);
    tv[13] = mk(1, 64'h00000000_00000600, 0, 0, 0, 0, 1, 1, 0, 4'h3, 4'h2, 0, 10'h20c, 64'h00000000_00000600, 0, 3);

    clear_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    step();
    chk("rst_code", 64'(code_o), 64'h210);
    chk("rst_pc", pc_o, 64'h0);
    chk("rst_dly", 64'(dly_o), 64'h0);
    chk("rst_kill", 64'(kill_o), 64'h0);
    chk("rst_squash", 64'(squash_o), 64'h0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk); apply(tv[i]);
      step();
      chk($sformatf("v%0d_code", i), 64'(code_o), 64'(tv[i].e_code));
      chk($sformatf("v%0d_pc", i), pc_o, tv[i].e_pc);
      chk($sformatf("v%0d_dly", i), 64'(dly_o), 64'(tv[i].e_dly));
      chk($sformatf("v%0d_kill", i), 64'(kill_o), 64'(tv[i].e_kill));
    end

    // flush window: arm dly_pend via a way1 branch, then flush with bundles every cycle
    @(negedge clk); clear_in(); in_valid = 2'b11; in_branch = 2'b10; in_pc = 64'h10;
    step();
    chk("fl_pre_code", 64'(code_o), 64'h210);
    @(negedge clk); exc_flush_all = 1'b1; in_syscall = 2'b01;
    step();
    chk("fl_f_code", 64'(code_o), 64'h210);
    chk("fl_f_kill", 64'(kill_o), 64'h0);
    chk("fl_f_sq", 64'(squash_o), 64'h1);
    @(negedge clk); exc_flush_all = 1'b0; in_branch = 2'b00;
    step();
    chk("fl_s1_code", 64'(code_o), 64'h210);
    chk("fl_s1_sq", 64'(squash_o), 64'h1);
    step();
    chk("fl_s2_code", 64'(code_o), 64'h210);
    chk("fl_s2_sq", 64'(squash_o), 64'h0);
    step();
    chk("fl_run_code", 64'(code_o), 64'h208);
    chk("fl_run_dly", 64'(dly_o), 64'h0);
    chk("fl_run_kill", 64'(kill_o), 64'h3);

    // reset in the middle of a squash window
    @(negedge clk); exc_flush_all = 1'b1;
    step();
    chk("mr_sq", 64'(squash_o), 64'h1);
    @(negedge clk); exc_flush_all = 1'b0; rst = 1'b0;
    step();
    chk("mr_sq0", 64'(squash_o), 64'h0);
    chk("mr_code", 64'(code_o), 64'h210);
    chk("mr_pc", pc_o, 64'h0);
    chk("mr_dly", 64'(dly_o), 64'h0);
    @(negedge clk); rst = 1'b1; clear_in(); in_valid = 2'b01; in_ri = 2'b01; in_pc = 64'h40;
    step();
    chk("mr_run_code", 64'(code_o), 64'h20a);
    chk("mr_run_pc", pc_o, 64'h40);
    chk("mr_run_kill", 64'(kill_o), 64'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
